// File: rtl/mdr_pkg.sv
// mdr_pkg
// Shared definitions for the iterative multiply / divide / square-root unit:
//   - opcode encodings (OP_MUL, OP_SQRT, OP_DIV, OP_RSV)
//   - FSM state enumeration (state_t)
//   - iteration counter width helper (CNT_W for the default word length,
//     cnt_width() for any other WORD_LENGTH)
`timescale 1ns/1ps
package mdr_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_SQRT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_SQR,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam int WORD_LENGTH_DEF = 16;
    localparam int CNT_W           = $clog2(WORD_LENGTH_DEF) + 1;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mdr_iter_counter.sv
// mdr_iter_counter
// Loadable down-counter that paces the iterative states of mdr_seq_unit.
// It is loaded with (iterations - 1) and flags the last iteration when it
// reaches zero; it never wraps below zero.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   load     load load_val (takes priority over en)
//   load_val value loaded on load
//   en       decrement enable
//   term     high while the count is zero (last iteration)
`timescale 1ns/1ps
module mdr_iter_counter import mdr_pkg::*; #(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          term
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign term = (count == '0);

endmodule

// File: rtl/mdr_seq_unit.sv
// mdr_seq_unit
// Iterative signed multiply, signed truncating divide and unsigned square
// root. One multiplier / quotient bit per cycle, two radicand bits per cycle.
// Optional feature macro: MDR_DIV_EN (defined = divider present; undefined =
// op 2'b10 is answered as a reserved opcode).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      command strobe, sampled only in IDLE
//   op         00 MUL, 01 SQRT, 10 DIV, 11 reserved
//   data_x     multiplicand / radicand / dividend
//   data_y     multiplier / divisor (ignored for SQRT)
//   busy       high in every state except IDLE
//   ready      one-cycle completion pulse
//   error      qualifies ready (reserved op or divide by zero)
//   result_hi  MUL product high half, DIV remainder, SQRT remainder
//   result_lo  MUL product low half, DIV quotient, SQRT root
`timescale 1ns/1ps
module mdr_seq_unit import mdr_pkg::*; #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [WORD_LENGTH-1:0] data_x,
    input  logic [WORD_LENGTH-1:0] data_y,
    output logic                   busy,
    output logic                   ready,
    output logic                   error,
    output logic [WORD_LENGTH-1:0] result_hi,
    output logic [WORD_LENGTH-1:0] result_lo
);

    localparam int W  = WORD_LENGTH;
    localparam int W2 = 2 * WORD_LENGTH;
    localparam int CW = cnt_width(WORD_LENGTH);

    state_t            state;
    logic [1:0]        op_r;
    logic [W-1:0]      x_r, y_r;
    logic              sx, sy;
    logic [W-1:0]      a_mag;   // multiplicand or divisor magnitude
    logic [W-1:0]      sh_q;    // multiplier / dividend->quotient / radicand shifter
    logic [W-1:0]      acc_hi;  // product high half
    logic [W-1:0]      root_q;
    logic signed [W+1:0] rem_r; // partial remainder (divide and root)

    logic              load_err;
    logic              cnt_term;
    logic [CW-1:0]     cnt_val;
    logic [W:0]        mul_sum;
    logic signed [W+1:0] sq_shift, sq_next;
    logic [W-1:0]      sq_rem_fix;
    logic [W-1:0]      fin_hi, fin_lo;
`ifdef MDR_DIV_EN
    logic signed [W+1:0] dv_m, dv_shift, dv_next;
    logic [W-1:0]      dv_rem;
`endif

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v) + W'(1) : v;
    endfunction

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
        return n ? (~v) + W'(1) : v;
    endfunction

    function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v, input logic n);
        return n ? (~v) + W2'(1) : v;
    endfunction

    assign cnt_val = (op_r == OP_SQRT) ? CW'(W/2 - 1) : CW'(W - 1);

    mdr_iter_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (state == S_LOAD),
        .load_val (cnt_val),
        .en       (state == S_MUL || state == S_SQR || state == S_DIV),
        .term     (cnt_term)
    );

    always_comb begin
        load_err = (op_r == OP_RSV);
`ifdef MDR_DIV_EN
        if (op_r == OP_DIV && y_r == '0) load_err = 1'b1;
`else
        if (op_r == OP_DIV) load_err = 1'b1;
`endif
    end

    // Iteration step: shift-add multiply, non-restoring root (and divide).
    always_comb begin
        mul_sum    = {1'b0, acc_hi} + {1'b0, (sh_q[0] ? a_mag : '0)};
        sq_shift   = $signed({rem_r[W-1:0], sh_q[W-1:W-2]});
        sq_next    = rem_r[W+1] ? sq_shift + $signed({root_q, 2'b11})
                                : sq_shift - $signed({root_q, 2'b01});
        // A negative final root remainder is restored by adding 2*root+1.
        sq_rem_fix = W'(rem_r[W+1] ? rem_r + $signed({1'b0, root_q, 1'b1}) : rem_r);
`ifdef MDR_DIV_EN
        dv_m     = $signed({2'b00, a_mag});
        dv_shift = $signed({rem_r[W:0], sh_q[W-1]});
        dv_next  = rem_r[W+1] ? dv_shift + dv_m : dv_shift - dv_m;
        dv_rem   = W'(rem_r[W+1] ? rem_r + dv_m : rem_r);
`endif
    end

    // Sign fix-up of the final magnitudes.
    always_comb begin
        {fin_hi, fin_lo} = neg_w2({acc_hi, sh_q}, sx ^ sy);
        case (op_r)
            OP_SQRT: begin
                fin_hi = sq_rem_fix;
                fin_lo = root_q;
            end
`ifdef MDR_DIV_EN
            OP_DIV: begin
                fin_hi = neg_w(dv_rem, sx);
                fin_lo = neg_w(sh_q, sx ^ sy);
            end
`endif
            default: ;
        endcase
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ready     <= 1'b0;
            error     <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD;
                    busy  <= 1'b1;
                end
                S_LOAD: begin
                    if (load_err) begin
                        state     <= S_DONE;
                        ready     <= 1'b1;
                        error     <= 1'b1;
                        result_hi <= '0;
                        result_lo <= '0;
                    end else begin
                        case (op_r)
                            OP_MUL:  state <= S_MUL;
                            OP_SQRT: state <= S_SQR;
`ifdef MDR_DIV_EN
                            default: state <= S_DIV;
`else
                            default: state <= S_IDLE;
`endif
                        endcase
                    end
                end
                S_MUL, S_SQR, S_DIV: if (cnt_term) state <= S_FIX;
                S_FIX: begin
                    state     <= S_DONE;
                    ready     <= 1'b1;
                    result_hi <= fin_hi;
                    result_lo <= fin_lo;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded in LOAD.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (start) begin
                op_r <= op;
                x_r  <= data_x;
                y_r  <= data_y;
            end
            S_LOAD: begin
                sx     <= x_r[W-1];
                sy     <= y_r[W-1];
                acc_hi <= '0;
                rem_r  <= '0;
                root_q <= '0;
                case (op_r)
                    OP_MUL: begin
                        a_mag <= mag(x_r);
                        sh_q  <= mag(y_r);
                    end
                    OP_SQRT: begin
                        a_mag <= '0;
                        sh_q  <= x_r;
                    end
                    default: begin
                        a_mag <= mag(y_r);
                        sh_q  <= mag(x_r);
                    end
                endcase
            end
            S_MUL: begin
                acc_hi <= mul_sum[W:1];
                sh_q   <= {mul_sum[0], sh_q[W-1:1]};
            end
            S_SQR: begin
                rem_r  <= sq_next;
                root_q <= {root_q[W-2:0], ~sq_next[W+1]};
                sh_q   <= {sh_q[W-3:0], 2'b00};
            end
`ifdef MDR_DIV_EN
            S_DIV: begin
                rem_r <= dv_next;
                sh_q  <= {sh_q[W-2:0], ~dv_next[W+1]};
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdr_seq_unit.sv
// tb_mdr_seq_unit
// Self-checking bench for mdr_seq_unit (WORD_LENGTH=16). Expected results
// come from plain integer arithmetic; honours MDR_DIV_EN like the design.
`timescale 1ns/1ps
module tb_mdr_seq_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] data_x, data_y;
    logic         busy, ready, error;
    logic [W-1:0] result_hi, result_lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdr_seq_unit #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .data_x    (data_x),
        .data_y    (data_y),
        .busy      (busy),
        .ready     (ready),
        .error     (error),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] eh, output logic [W-1:0] el,
                             output logic e, output int lat);
        longint a, b, p, r, ux;
        logic [63:0] t;
        a = $signed(x);
        b = $signed(y);
        eh = '0; el = '0; e = 1'b1; lat = 2;
        case (o)
            2'b00: begin
                p = a * b; t = p;
                eh = t[2*W-1:W]; el = t[W-1:0]; e = 1'b0; lat = W + 3;
            end
            2'b01: begin
                ux = longint'(x); r = 0;
                while ((r + 1) * (r + 1) <= ux) r++;
                t = r; el = t[W-1:0];
                t = ux - r * r; eh = t[W-1:0];
                e = 1'b0; lat = W/2 + 3;
            end
            2'b10: begin
`ifdef MDR_DIV_EN
                if (b != 0) begin
                    t = a / b; el = t[W-1:0];
                    t = a % b; eh = t[W-1:0];
                    e = 1'b0; lat = W + 3;
                end
`endif
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int extra_cyc, input int abort_cyc);
        logic [W-1:0] eh, el;
        logic         e;
        int           exp_lat, lat, pulses;
        bit           seen;
        ref_model(o, x, y, eh, el, e, exp_lat);
        @(negedge clk);
        start = 1'b1; op = o; data_x = x; data_y = y;
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (lat == 1) chk("busy_cycle1", 64'(busy), 64'(1));
            if (extra_cyc != 0 && lat == extra_cyc) begin
                start = 1'b1; op = 2'b00;
                data_x = W'($urandom); data_y = W'($urandom);
            end
            if (abort_cyc != 0 && lat == abort_cyc) begin
                reset = 1'b0;
                #1;
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_ready", 64'(ready), 64'(0));
                chk("abort_error", 64'(error), 64'(0));
                chk("abort_hi", 64'(result_hi), 64'(0));
                chk("abort_lo", 64'(result_lo), 64'(0));
                repeat (2) @(negedge clk);
                reset = 1'b1;
                pulses = 0;
                repeat (25) begin
                    @(negedge clk);
                    if (ready) pulses++;
                end
                chk("abort_no_ready", 64'(pulses), 64'(0));
                return;
            end
            if (ready) seen = 1;
        end
        chk($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat));
        chk($sformatf("error op%0d x=%0h y=%0h", o, x, y), 64'(error), 64'(e));
        chk($sformatf("hi op%0d x=%0h y=%0h", o, x, y), 64'(result_hi), 64'(eh));
        chk($sformatf("lo op%0d x=%0h y=%0h", o, x, y), 64'(result_lo), 64'(el));
        @(negedge clk);
        chk("ready_pulse_end", 64'(ready), 64'(0));
        chk("busy_after_ready", 64'(busy), 64'(0));
        chk("hold_lo", 64'(result_lo), 64'(el));
        if (extra_cyc != 0) begin
            pulses = 0;
            repeat (25) begin
                @(negedge clk);
                if (ready) pulses++;
            end
            chk("ignored_start_pulses", 64'(pulses), 64'(0));
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h0001;
            4: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; data_x = '0; data_y = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_hi", 64'(result_hi), 64'(0));
        chk("rst_lo", 64'(result_lo), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        run_op(2'b00, 16'd300, 16'hFFF9, 0, 0);
        run_op(2'b01, 16'd1000, 16'h1234, 0, 0);
        run_op(2'b01, 16'hFFFF, 16'h0000, 0, 0);
        run_op(2'b10, 16'd100, 16'd7, 0, 0);
        run_op(2'b10, 16'hFF9C, 16'd7, 0, 0);
        run_op(2'b10, 16'h8000, 16'hFFFF, 0, 0);
        run_op(2'b10, 16'd5, 16'd0, 0, 0);
        run_op(2'b11, 16'd9, 16'd3, 0, 0);
        run_op(2'b00, 16'h8000, 16'h8000, 0, 0);
        run_op(2'b00, 16'd1234, 16'hFF00, 5, 0);
`ifdef MDR_DIV_EN
        run_op(2'b10, 16'h7FFF, 16'd3, 0, 8);
`else
        run_op(2'b00, 16'h7FFF, 16'd3, 0, 8);
`endif
        run_op(2'b00, 16'd17, 16'd19, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]   o;
            logic [W-1:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            run_op(o, x, y, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
